cache_way_param: RTL and testbench
==================================

Name: cache_way_param

Overview:
Parametrised single cache way and successor to the fixed 4-word way. It provides:
- configurable sets, words per line, word width and tag width;
- tag storage with valid and dirty bits, plus a registered hit compare;
- byte-enabled store writes;
- a sequenced word-by-word line refill;
- a walking invalidate-all engine.

It sits under the set-associative cache controller, which instantiates one per way and does victim selection externally.

Parameters:
ADDR_WIDTH, 5, index bits; SETS = 1 << ADDR_WIDTH
WORD_NUM, 4, words per line (power of two, >= 2)
WORD_WIDTH, 32, bits per word (multiple of 8)
TAG_BITS, 23, tag width
LINE_WIDTH, WORD_NUM*WORD_WIDTH, derived; not to be overridden

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
addr  in  ADDR_WIDTH  set index for rd, wr and fill_start
lookup_tag  in  TAG_BITS  tag compared on rd_en
rd_en  in  1  lookup/read request
rd_valid  out  1  rd result valid (one cycle after rd_en)
hit  out  1  valid && tag match, qualified by rd_valid
rd_data  out  LINE_WIDTH  full line read
rd_tag  out  TAG_BITS  stored tag (for writeback address)
rd_dirty  out  1  stored dirty bit
wr_en  in  1  store write into a resident line
wr_word_en  in  WORD_NUM  word select
wr_byte_en  in  WORD_WIDTH/8  byte enables, applied to every selected word
wr_data  in  LINE_WIDTH  store data, word-aligned lanes
fill_start  in  1  begin refill of set addr with fill_tag
fill_tag  in  TAG_BITS  tag for refilled line
fill_valid  in  1  refill beat valid
fill_data  in  WORD_WIDTH  refill word, ascending word order
fill_ready  out  1  beat accepted when fill_valid && fill_ready
fill_done  out  1  one-cycle pulse, line now valid
inv_all  in  1  start invalidate-all
busy  out  1  FILL or INV in progress; rd_en/wr_en ignored

Behaviour:
- FSM states: IDLE, FILL, INV.
- Reset (async assert, sync deassert upstream): state IDLE, all valid and dirty bits 0, word counter 0, set counter 0. Outputs rd_valid, hit, rd_dirty, fill_ready, fill_done, busy are all 0; rd_data and rd_tag are 0. Data RAM is not reset.
- Read: rd_en in IDLE at cycle N registers addr/lookup_tag. rd_valid=1 at N+1 with rd_data, rd_tag, rd_dirty and hit. Read-first: a same-cycle wr_en to the same set returns pre-write data. rd_valid is 0 whenever busy.
- Write: wr_en in IDLE writes selected bytes of selected words at the clock edge and sets dirty[addr]. No tag check is done here; the controller guarantees residency.
- wr_en with wr_word_en=0: no data change, dirty unchanged.
- Fill:
  - fill_start in IDLE latches addr and fill_tag, clears valid[addr], and goes to FILL. fill_ready=1 in FILL.
  - Each accepted beat writes word[cnt] and increments cnt.
  - On the beat with cnt==WORD_NUM-1: valid=1, tag=fill_tag, dirty=0, cnt wraps to 0, fill_done pulses in the next cycle, state returns to IDLE.
  - Gaps in fill_valid are allowed.
- Invalidate-all: inv_all in IDLE goes to INV. One set is cleared per cycle (valid=0, dirty=0) from set 0 to SETS-1, then IDLE. busy=1 for exactly SETS cycles.
- Priority in IDLE: inv_all > fill_start > wr_en/rd_en. fill_start and inv_all while busy are ignored.
- Reset mid-FILL: the line stays invalid. Reset mid-INV: all bits are cleared anyway.

Optional Feature:
CACHE_WAY_DIRTY_EN
- Defined: dirty array implemented, set by wr_en, cleared by fill/inv/reset; rd_dirty reflects the stored bit.
- Undefined: no dirty storage; rd_dirty tied 0. This is for write-through configurations.

Decomposition:
- Package cache_pkg holds the FSM state enum (IDLE/FILL/INV) and a line-width helper function.
- Sub-module cache_bank_ram: one WORD_WIDTH-wide, byte-enabled, SETS-deep synchronous RAM. It is instantiated WORD_NUM times via generate. The fill path muxes its write port against the store path.

Test Plan:
- Reset, then rd_en addr=3 tag=0x12 -> rd_valid=1 next cycle, hit=0, rd_dirty=0.
- fill_start addr=3 tag=0x12, four beats 0x11111111..0x44444444 with one-cycle gap after beat 2 -> fill_done 1 cycle after beat 4; rd addr=3 tag=0x12 gives hit=1, rd_data=0x44444444_33333333_22222222_11111111, rd_dirty=0.
- wr_en addr=3 wr_word_en=0b0010 wr_byte_en=0b0001 data lane1=0xAB -> word1 reads 0x222222AB, rd_dirty=1 (0 with macro undefined); same-cycle rd returns old 0x22222222.
- rd addr=3 tag=0x13 -> hit=0, rd_tag=0x12.
- inv_all -> busy high exactly 32 cycles, rd_en ignored during busy; afterwards rd addr=3 tag=0x12 gives hit=0.
- rst_n low after beat 2 of a fill to set 5 -> fill_ready=0, state IDLE; rd addr=5 gives hit=0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the parametrised cache way: FSM state encoding and line-width helper.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        INV  = 2'd2
    } way_state_e;

    function automatic int line_width(input int words, input int width);
        return words * width;
    endfunction

endpackage

// File: rtl/cache_bank_ram.sv
// One word-wide bank of the data array: byte-enabled synchronous write, registered
// read-first read port. The storage itself is not reset; only the read register is.
module cache_bank_ram #(
    parameter int ADDR_WIDTH = 5,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH/8-1:0]    i_be,
    input  logic [WIDTH-1:0]      i_wdata
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int b = 0; b < WIDTH/8; b++) begin
            if (i_we && i_be[b])
                r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
    end

    // Same-edge write lands after this sample, giving read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rdata <= '0;
        else if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cache_way_param.sv
// Parametrised single cache way: tags/valid/dirty, registered hit, byte-enabled stores,
// sequenced refill and walking invalidate-all. Dirty storage guarded by CACHE_WAY_DIRTY_EN.
module cache_way_param
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int WORD_NUM   = 4,
    parameter int WORD_WIDTH = 32,
    parameter int TAG_BITS   = 23,
    parameter int LINE_WIDTH = line_width(WORD_NUM, WORD_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [TAG_BITS-1:0]     lookup_tag,
    input  logic                    rd_en,
    output logic                    rd_valid,
    output logic                    hit,
    output logic [LINE_WIDTH-1:0]   rd_data,
    output logic [TAG_BITS-1:0]     rd_tag,
    output logic                    rd_dirty,
    input  logic                    wr_en,
    input  logic [WORD_NUM-1:0]     wr_word_en,
    input  logic [WORD_WIDTH/8-1:0] wr_byte_en,
    input  logic [LINE_WIDTH-1:0]   wr_data,
    input  logic                    fill_start,
    input  logic [TAG_BITS-1:0]     fill_tag,
    input  logic                    fill_valid,
    input  logic [WORD_WIDTH-1:0]   fill_data,
    output logic                    fill_ready,
    output logic                    fill_done,
    input  logic                    inv_all,
    output logic                    busy
);
    localparam int SETS  = 1 << ADDR_WIDTH;
    localparam int CNT_W = $clog2(WORD_NUM);
    localparam int BE_W  = WORD_WIDTH / 8;

    way_state_e              r_state, w_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [ADDR_WIDTH-1:0]   r_set;
    logic [ADDR_WIDTH-1:0]   r_fill_set;
    logic [TAG_BITS-1:0]     r_fill_tag;
    logic [SETS-1:0]         r_valid;
    logic [TAG_BITS-1:0]     r_tag [SETS];
    logic                    r_rd_valid, r_hit, r_fill_done;
    logic [TAG_BITS-1:0]     r_rd_tag;

    logic w_rd_acc, w_wr_acc, w_fill_go, w_fill_acc, w_fill_last, w_inv_go;

    always_comb begin
        w_next      = r_state;
        w_rd_acc    = 1'b0;
        w_wr_acc    = 1'b0;
        w_fill_go   = 1'b0;
        w_fill_acc  = 1'b0;
        w_fill_last = 1'b0;
        w_inv_go    = 1'b0;
        case (r_state)
            IDLE: begin
                if (inv_all) begin
                    w_inv_go = 1'b1;
                    w_next   = INV;
                end else if (fill_start) begin
                    w_fill_go = 1'b1;
                    w_next    = FILL;
                end else begin
                    w_rd_acc = rd_en;
                    w_wr_acc = wr_en;
                end
            end
            FILL: begin
                w_fill_acc = fill_valid;
                if (fill_valid && r_cnt == CNT_W'(WORD_NUM-1)) begin
                    w_fill_last = 1'b1;
                    w_next      = IDLE;
                end
            end
            INV: begin
                if (r_set == ADDR_WIDTH'(SETS-1))
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_set       <= '0;
            r_fill_set  <= '0;
            r_fill_tag  <= '0;
            r_valid     <= '0;
            r_rd_valid  <= 1'b0;
            r_hit       <= 1'b0;
            r_rd_tag    <= '0;
            r_fill_done <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_rd_valid  <= w_rd_acc;
            r_hit       <= w_rd_acc && r_valid[addr] && (r_tag[addr] == lookup_tag);
            r_fill_done <= w_fill_last;
            if (w_rd_acc)
                r_rd_tag <= r_tag[addr];
            if (w_fill_go) begin
                r_fill_set    <= addr;
                r_fill_tag    <= fill_tag;
                r_valid[addr] <= 1'b0;
            end
            // Counter is a power of two wide, so the last beat wraps it to 0.
            if (w_fill_acc)
                r_cnt <= r_cnt + 1'b1;
            if (w_fill_last)
                r_valid[r_fill_set] <= 1'b1;
            if (w_inv_go)
                r_set <= '0;
            else if (r_state == INV) begin
                r_valid[r_set] <= 1'b0;
                r_set          <= r_set + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill_last)
            r_tag[r_fill_set] <= r_fill_tag;
    end

`ifdef CACHE_WAY_DIRTY_EN
    logic [SETS-1:0] r_dirty;
    logic            r_rd_dirty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dirty    <= '0;
            r_rd_dirty <= 1'b0;
        end else begin
            if (w_rd_acc)
                r_rd_dirty <= r_dirty[addr];
            if (w_wr_acc && |wr_word_en)
                r_dirty[addr] <= 1'b1;
            if (w_fill_last)
                r_dirty[r_fill_set] <= 1'b0;
            if (r_state == INV)
                r_dirty[r_set] <= 1'b0;
        end
    end

    assign rd_dirty = r_rd_valid & r_rd_dirty;
`else
    assign rd_dirty = 1'b0;
`endif

    for (genvar g = 0; g < WORD_NUM; g++) begin : g_bank
        logic                  w_we;
        logic [BE_W-1:0]       w_be;
        logic [WORD_WIDTH-1:0] w_wd;
        logic [ADDR_WIDTH-1:0] w_wa;

        // Refill beats own the write port while in FILL; stores only occur in IDLE.
        assign w_we = w_fill_acc ? (r_cnt == CNT_W'(g)) : (w_wr_acc & wr_word_en[g]);
        assign w_be = w_fill_acc ? {BE_W{1'b1}} : wr_byte_en;
        assign w_wd = w_fill_acc ? fill_data : wr_data[g*WORD_WIDTH +: WORD_WIDTH];
        assign w_wa = w_fill_acc ? r_fill_set : addr;

        cache_bank_ram #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .WIDTH      (WORD_WIDTH)
        ) u_ram (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_re    (w_rd_acc),
            .i_raddr (addr),
            .o_rdata (rd_data[g*WORD_WIDTH +: WORD_WIDTH]),
            .i_we    (w_we),
            .i_waddr (w_wa),
            .i_be    (w_be),
            .i_wdata (w_wd)
        );
    end

    assign rd_valid   = r_rd_valid;
    assign hit        = r_rd_valid & r_hit;
    assign rd_tag     = r_rd_tag;
    assign fill_ready = (r_state == FILL);
    assign fill_done  = r_fill_done;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_cache_way_param.sv
// Directed self-checking bench for cache_way_param (default parameters).
module tb_cache_way_param;
    localparam int AW = 5, WN = 4, WW = 32, TB = 23, LW = WN*WW;
`ifdef CACHE_WAY_DIRTY_EN
    localparam bit DIRTY = 1'b1;
`else
    localparam bit DIRTY = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [TB-1:0] lookup_tag = '0, fill_tag = '0, rd_tag;
    logic          rd_en = 0, wr_en = 0, fill_start = 0, fill_valid = 0, inv_all = 0;
    logic          rd_valid, hit, rd_dirty, fill_ready, fill_done, busy;
    logic [LW-1:0] rd_data, wr_data = '0;
    logic [WN-1:0] wr_word_en = '0;
    logic [WW/8-1:0] wr_byte_en = '0;
    logic [WW-1:0] fill_data = '0;

    int n_checks = 0, n_pass = 0;

    cache_way_param dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .lookup_tag(lookup_tag), .rd_en(rd_en),
        .rd_valid(rd_valid), .hit(hit), .rd_data(rd_data), .rd_tag(rd_tag), .rd_dirty(rd_dirty),
        .wr_en(wr_en), .wr_word_en(wr_word_en), .wr_byte_en(wr_byte_en), .wr_data(wr_data),
        .fill_start(fill_start), .fill_tag(fill_tag), .fill_valid(fill_valid),
        .fill_data(fill_data), .fill_ready(fill_ready), .fill_done(fill_done),
        .inv_all(inv_all), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [TB-1:0] t);
        addr = a; lookup_tag = t; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({rd_valid, hit, rd_dirty, fill_ready, fill_done, busy} !== 6'b0)
            $display("FAIL reset_flags got=%b exp=000000",
                     {rd_valid, hit, rd_dirty, fill_ready, fill_done, busy});
        else n_pass++;
        n_checks++;
        if (rd_data !== '0 || rd_tag !== '0)
            $display("FAIL reset_data got data=%h tag=%h exp 0", rd_data, rd_tag);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        tick();
        do_read(5'd3, 23'h12);
        n_checks++;
        if (rd_valid !== 1'b1 || hit !== 1'b0 || rd_dirty !== 1'b0)
            $display("FAIL cold_read got v=%b h=%b d=%b exp v=1 h=0 d=0", rd_valid, hit, rd_dirty);
        else n_pass++;
    endtask

    task automatic test_fill();
        addr = 5'd3; fill_tag = 23'h12; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        n_checks++;
        if (fill_ready !== 1'b1 || busy !== 1'b1)
            $display("FAIL fill_enter got rdy=%b busy=%b exp 1 1", fill_ready, busy);
        else n_pass++;
        fill_valid = 1'b1; fill_data = 32'h11111111; tick();
        fill_data = 32'h22222222; tick();
        fill_valid = 1'b0; tick();
        n_checks++;
        if (fill_done !== 1'b0 || fill_ready !== 1'b1)
            $display("FAIL fill_gap got done=%b rdy=%b exp 0 1", fill_done, fill_ready);
        else n_pass++;
        fill_valid = 1'b1; fill_data = 32'h33333333; tick();
        fill_data = 32'h44444444; tick();
        fill_valid = 1'b0;
        n_checks++;
        if (fill_done !== 1'b1 || busy !== 1'b0 || fill_ready !== 1'b0)
            $display("FAIL fill_done got done=%b busy=%b rdy=%b exp 1 0 0", fill_done, busy, fill_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (fill_done !== 1'b0)
            $display("FAIL fill_done_pulse got=%b exp=0", fill_done);
        else n_pass++;
        do_read(5'd3, 23'h12);
        n_checks++;
        if (hit !== 1'b1 || rd_data !== 128'h44444444_33333333_22222222_11111111 ||
            rd_dirty !== 1'b0 || rd_tag !== 23'h12)
            $display("FAIL fill_read got h=%b data=%h d=%b tag=%h exp h=1 data=44444444333333332222222211111111 d=0 tag=12",
                     hit, rd_data, rd_dirty, rd_tag);
        else n_pass++;
    endtask

    task automatic test_store();
        addr = 5'd3; lookup_tag = 23'h12;
        wr_en = 1'b1; wr_word_en = 4'b0010; wr_byte_en = 4'b0001;
        wr_data = '0; wr_data[63:32] = 32'h000000AB;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++;
        if (rd_data[63:32] !== 32'h22222222 || rd_dirty !== 1'b0)
            $display("FAIL store_read_first got w1=%h d=%b exp 22222222 0", rd_data[63:32], rd_dirty);
        else n_pass++;
        do_read(5'd3, 23'h12);
        n_checks++;
        if (rd_data !== 128'h44444444_33333333_222222AB_11111111 || rd_dirty !== DIRTY || hit !== 1'b1)
            $display("FAIL store_after got data=%h d=%b h=%b exp 44444444333333332222_22AB11111111 d=%b h=1",
                     rd_data, rd_dirty, hit, DIRTY);
        else n_pass++;
        // No selected words: data untouched; set 4 never written so it stays clean.
        wr_en = 1'b1; wr_word_en = 4'b0000; wr_byte_en = 4'b1111; wr_data = '1;
        addr = 5'd3; tick();
        addr = 5'd4; tick();
        wr_en = 1'b0;
        do_read(5'd3, 23'h12);
        n_checks++;
        if (rd_data !== 128'h44444444_33333333_222222AB_11111111)
            $display("FAIL store_no_word got data=%h exp 44444444333333332222_22AB11111111", rd_data);
        else n_pass++;
        do_read(5'd4, 23'h0);
        n_checks++;
        if (rd_dirty !== 1'b0 || hit !== 1'b0)
            $display("FAIL store_no_word_dirty got d=%b h=%b exp 0 0", rd_dirty, hit);
        else n_pass++;
    endtask

    task automatic test_miss();
        do_read(5'd3, 23'h13);
        n_checks++;
        if (hit !== 1'b0 || rd_tag !== 23'h12 || rd_valid !== 1'b1)
            $display("FAIL tag_miss got h=%b tag=%h v=%b exp h=0 tag=12 v=1", hit, rd_tag, rd_valid);
        else n_pass++;
    endtask

    task automatic test_inv();
        int  cycles = 0;
        bit  leak = 1'b0;
        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        addr = 5'd3; lookup_tag = 23'h12; rd_en = 1'b1;
        while (busy === 1'b1 && cycles < 100) begin
            if (rd_valid !== 1'b0) leak = 1'b1;
            cycles++;
            tick();
        end
        n_checks++;
        if (cycles !== 32)
            $display("FAIL inv_busy_len got=%0d exp=32", cycles);
        else n_pass++;
        n_checks++;
        if (leak || rd_valid !== 1'b0)
            $display("FAIL inv_rd_ignored got leak=%b v=%b exp 0 0", leak, rd_valid);
        else n_pass++;
        tick();
        rd_en = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b1 || hit !== 1'b0 || rd_dirty !== 1'b0)
            $display("FAIL inv_after got v=%b h=%b d=%b exp 1 0 0", rd_valid, hit, rd_dirty);
        else n_pass++;
    endtask

    task automatic test_priority();
        int cycles = 0;
        addr = 5'd7; fill_tag = 23'h7; inv_all = 1'b1; fill_start = 1'b1; wr_en = 1'b1;
        wr_word_en = 4'b1111; wr_byte_en = 4'b1111;
        tick();
        inv_all = 1'b0; fill_start = 1'b0; wr_en = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || fill_ready !== 1'b0)
            $display("FAIL prio_inv got busy=%b rdy=%b exp 1 0", busy, fill_ready);
        else n_pass++;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            tick();
        end
        n_checks++;
        if (busy !== 1'b0)
            $display("FAIL prio_inv_timeout got busy=%b exp 0", busy);
        else n_pass++;
        do_read(5'd7, 23'h0);
        n_checks++;
        if (rd_dirty !== 1'b0)
            $display("FAIL prio_no_store got d=%b exp 0", rd_dirty);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        addr = 5'd9; fill_tag = 23'h5A5A5; fill_start = 1'b1;
        tick();
        fill_start = 1'b0; fill_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fill_data = 32'hA0000000 + 32'(i);
            tick();
        end
        fill_valid = 1'b0;
        n_checks++;
        if (fill_done !== 1'b1)
            $display("FAIL b2b_done got=%b exp=1", fill_done);
        else n_pass++;
        do_read(5'd9, 23'h5A5A5);
        n_checks++;
        if (hit !== 1'b1 || rd_data !== 128'hA0000003_A0000002_A0000001_A0000000)
            $display("FAIL b2b_read got h=%b data=%h exp h=1 A0000003A0000002A0000001A0000000", hit, rd_data);
        else n_pass++;
    endtask

    task automatic test_reset_mid_fill();
        addr = 5'd5; fill_tag = 23'h20; fill_start = 1'b1;
        tick();
        fill_start = 1'b0; fill_valid = 1'b1;
        fill_data = 32'hDEAD0001; tick();
        fill_data = 32'hDEAD0002; tick();
        fill_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (fill_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL rst_mid_fill got rdy=%b busy=%b exp 0 0", fill_ready, busy);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        tick();
        do_read(5'd5, 23'h20);
        n_checks++;
        if (hit !== 1'b0 || rd_valid !== 1'b1)
            $display("FAIL rst_fill_read got h=%b v=%b exp 0 1", hit, rd_valid);
        else n_pass++;
        do_read(5'd9, 23'h5A5A5);
        n_checks++;
        if (hit !== 1'b0)
            $display("FAIL rst_clears_valid got h=%b exp 0", hit);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_store();
        test_miss();
        test_inv();
        test_priority();
        test_back_to_back();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
